// File: rtl/async_fifo_wr_ctrl_pkg.sv
// Shared pointer helpers for the dual-clock FIFO controllers.
// Gray/binary conversions work on a wide word; callers cast to width.
package async_fifo_wr_ctrl_pkg;

  localparam int GW = 32;

  function automatic int ptr_width(input int aw);
    return aw + 1;
  endfunction

  function automatic logic [GW-1:0] bin2gray(
    input logic [GW-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

  function automatic logic [GW-1:0] gray2bin(
    input logic [GW-1:0] g
  );
    logic [GW-1:0] b;
    b = '0;
    b[GW-1] = g[GW-1];
    for (int i = GW - 2; i >= 0; i--)
      b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/async_fifo_wr_ctrl_sync.sv
// Two-flop synchronizer for a gray-coded pointer crossing clock domains.
// Shared by the read- and write-side FIFO controllers.
module gray_ptr_sync #(
  parameter int P = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [P-1:0] d,
  output logic [P-1:0] q
);

  logic [P-1:0] s1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/async_fifo_wr_ctrl.sv
// Write-side pointer and flag controller of a dual-clock FIFO.
// Flags are registered from the next pointer so full never lags a write.
module async_fifo_wr_ctrl
  import async_fifo_wr_ctrl_pkg::*;
#(
  parameter  int addrWidth        = 4,
  parameter  int almostFullThresh = 2,
  localparam int P = ptr_width(addrWidth)
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 enq__ENA,
  output logic                 enq__RDY,
  output logic                 ram_we,
  output logic [addrWidth-1:0] ram_waddr,
  input  logic [P-1:0]         rptrGray,
  output logic [P-1:0]         wptrGray,
  output logic                 full,
  output logic                 almostFull,
  output logic [P-1:0]         level,
  output logic                 overflow
);

  localparam int DEPTH = 1 << addrWidth;
  localparam logic [P-1:0] DEPTH_P = P'(DEPTH);
  localparam logic [P-1:0] THR_P   = P'(almostFullThresh);
  // Full when the write pointer equals the read pointer with the top two gray bits inverted.
  localparam logic [P-1:0] FLIP    = P'(3) << (P - 2);

  logic [P-1:0] wbin;
  logic [P-1:0] wbin_next;
  logic [P-1:0] gray_next;
  logic [P-1:0] sync2;
  logic [P-1:0] rbin_sync;
  logic [P-1:0] level_next;
  logic [P-1:0] free_next;
  logic         accept;
  logic         full_next;
  logic         af_next;

  gray_ptr_sync #(
    .P(P)
  ) u_sync (
    .clk  (CLK),
    .rst_n(nRST),
    .d    (rptrGray),
    .q    (sync2)
  );

  assign enq__RDY  = !full;
  assign accept    = enq__ENA & enq__RDY;
  assign ram_we    = accept & nRST;
  assign ram_waddr = wbin[addrWidth-1:0];

  always_comb begin
    wbin_next  = accept ? wbin + P'(1) : wbin;
    gray_next  = P'(bin2gray(GW'(wbin_next)));
    rbin_sync  = P'(gray2bin(GW'(sync2)));
    level_next = wbin_next - rbin_sync;
    free_next  = DEPTH_P - level_next;
    full_next  = gray_next == (sync2 ^ FLIP);
    af_next    = free_next <= THR_P;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      wbin       <= '0;
      wptrGray   <= '0;
      full       <= 1'b0;
      almostFull <= 1'b0;
      level      <= '0;
      overflow   <= 1'b0;
    end else begin
      wbin       <= wbin_next;
      wptrGray   <= gray_next;
      full       <= full_next;
      almostFull <= af_next;
      level      <= level_next;
      overflow   <= overflow | (enq__ENA & full);
    end
  end

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// Directed bench for the FIFO write-side controller.
// Vector table plus hand sequences for wrap and mid-stream reset.
module tb_async_fifo_wr_ctrl;

  localparam int AW = 4;
  localparam int P  = AW + 1;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          ena;
  logic          rdy;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [P-1:0]  rptr;
  logic [P-1:0]  wptr;
  logic          full;
  logic          af;
  logic [P-1:0]  level;
  logic          ovf;

  int total  = 0;
  int passed = 0;

  async_fifo_wr_ctrl #(
    .addrWidth       (AW),
    .almostFullThresh(2)
  ) dut (
    .CLK       (clk),
    .nRST      (n_rst),
    .enq__ENA  (ena),
    .enq__RDY  (rdy),
    .ram_we    (ram_we),
    .ram_waddr (ram_waddr),
    .rptrGray  (rptr),
    .wptrGray  (wptr),
    .full      (full),
    .almostFull(af),
    .level     (level),
    .overflow  (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst_n;
    logic         ena;
    logic [P-1:0] rptr;
    logic         chk_pre;
    logic         we;
    logic [AW-1:0] waddr;
    logic         rdy;
    logic [P-1:0] wptr;
    logic         full;
    logic         af;
    logic [P-1:0] level;
    logic         ovf;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [P-1:0] g(input int b);
    logic [P-1:0] x;
    x = P'(b);
    return x ^ (x >> 1);
  endfunction

  function automatic vec_t mk(
    input logic rst_n, input logic e, input logic [P-1:0] rp,
    input logic cp, input logic we, input logic [AW-1:0] wa,
    input logic rd, input logic [P-1:0] wp, input logic fu,
    input logic a, input logic [P-1:0] lv, input logic o
  );
    vec_t v;
    v.rst_n = rst_n; v.ena = e; v.rptr = rp;
    v.chk_pre = cp; v.we = we; v.waddr = wa; v.rdy = rd;
    v.wptr = wp; v.full = fu; v.af = a; v.level = lv; v.ovf = o;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_rst = 1'b0; ena = 1'b0; rptr = '0;
    end
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  initial begin
    logic [P-1:0] prev;
    n_rst = 1'b0; ena = 1'b0; rptr = '0;

    tbl.push_back(mk(0,0,0, 0,0,0,0, 5'b00000,0,0,0,0));
    tbl.push_back(mk(0,0,0, 0,0,0,0, 5'b00000,0,0,0,0));
    for (int i = 0; i < 16; i++)
      tbl.push_back(mk(1,1,0, 1,1,AW'(i),1,
                       g(i+1), i == 15, i >= 13, P'(i+1), 0));
    tbl.push_back(mk(1,1,0, 1,0,0,0, 5'b11000,1,1,16,1));
    tbl.push_back(mk(1,0,5'b00001, 1,0,0,0, 5'b11000,1,1,16,1));
    tbl.push_back(mk(1,0,5'b00001, 1,0,0,0, 5'b11000,1,1,16,1));
    tbl.push_back(mk(1,0,5'b00001, 1,0,0,0, 5'b11000,0,1,15,1));
    tbl.push_back(mk(1,1,5'b00001, 1,1,0,1, 5'b11001,1,1,16,1));
    tbl.push_back(mk(1,1,5'b00001, 1,0,1,0, 5'b11001,1,1,16,1));

    foreach (tbl[k]) begin
      @(negedge clk);
      n_rst = tbl[k].rst_n; ena = tbl[k].ena; rptr = tbl[k].rptr;
      #1;
      if (tbl[k].chk_pre) begin
        chk($sformatf("v%0d we", k), 32'(ram_we), 32'(tbl[k].we));
        chk($sformatf("v%0d waddr", k), 32'(ram_waddr), 32'(tbl[k].waddr));
        chk($sformatf("v%0d rdy", k), 32'(rdy), 32'(tbl[k].rdy));
      end
      @(posedge clk);
      #1;
      chk($sformatf("v%0d wptr", k), 32'(wptr), 32'(tbl[k].wptr));
      chk($sformatf("v%0d full", k), 32'(full), 32'(tbl[k].full));
      chk($sformatf("v%0d af", k), 32'(af), 32'(tbl[k].af));
      chk($sformatf("v%0d level", k), 32'(level), 32'(tbl[k].level));
      chk($sformatf("v%0d ovf", k), 32'(ovf), 32'(tbl[k].ovf));
    end

    // Wrap: read pointer trails the write pointer by two.
    do_reset();
    chk("wrap rst ovf", 32'(ovf), 32'(0));
    prev = wptr;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      ena = 1'b1; rptr = g((k - 2) & 31);
      #1;
      chk($sformatf("wrap%0d we", k), 32'(ram_we), 32'(1));
      @(posedge clk);
      #1;
      chk($sformatf("wrap%0d wptr", k), 32'(wptr), 32'(g((k + 1) & 31)));
      chk($sformatf("wrap%0d onebit", k), 32'($countones(wptr ^ prev)), 32'(1));
      chk($sformatf("wrap%0d full", k), 32'(full), 32'(0));
      prev = wptr;
    end
    @(negedge clk);
    ena = 1'b0; rptr = g(38);
    repeat (3) @(posedge clk);
    #1;
    chk("wrap level", 32'(level), 32'(2));
    chk("wrap full", 32'(full), 32'(0));
    chk("wrap wptr", 32'(wptr), 32'(g(40)));

    // Reset while a write is being requested.
    do_reset();
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      ena = 1'b1; rptr = '0;
    end
    @(negedge clk);
    ena = 1'b0;
    #1;
    chk("mid level9", 32'(level), 32'(9));
    chk("mid wptr9", 32'(wptr), 32'(g(9)));
    @(negedge clk);
    n_rst = 1'b0; ena = 1'b1;
    #1;
    chk("mid rst we", 32'(ram_we), 32'(0));
    @(posedge clk);
    #1;
    chk("mid rst wptr", 32'(wptr), 32'(0));
    chk("mid rst level", 32'(level), 32'(0));
    chk("mid rst full", 32'(full), 32'(0));
    chk("mid rst ovf", 32'(ovf), 32'(0));
    @(negedge clk);
    n_rst = 1'b1; ena = 1'b0;
    #1;
    chk("mid rdy", 32'(rdy), 32'(1));
    chk("mid waddr", 32'(ram_waddr), 32'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
